// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the 4:1 mux scan sequencer.
package mux_scan_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
    localparam int NCH     = 4;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;
endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 while enabled; tc flags the last cycle of a dwell.
module dwell_counter
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] count;

    assign tc = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, samples each after its dwell and
// hands the assembled vector out over valid/ready, once or continuously.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic [SEL_W-1:0] s,
    input  logic             y,
    output logic [NCH-1:0]   sample,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);
    scan_state_t        state, state_n;
    logic               mode_q;
    logic [NCH-2:0]     shadow;
    logic               tc;
    logic               accept, step, finish, handshake;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (accept | handshake),
        .en  (state == SCAN),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (tc) begin
                    step = 1'b1;
                    if (s == SEL_W'(NCH - 1)) begin
                        finish  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (valid && ready) begin
                    handshake = 1'b1;
                    state_n   = mode_q ? SCAN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The last channel bypasses the shadow and lands directly in sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s      <= '0;
            shadow <= '0;
            sample <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            if (accept) begin
                mode_q <= mode;
                s      <= '0;
            end
            if (step) begin
                for (int k = 0; k < NCH - 1; k++) begin
                    if (s == SEL_W'(k)) shadow[k] <= y;
                end
                s <= s + 1'b1;
            end
            if (finish) begin
                sample <= {y, shadow};
                valid  <= 1'b1;
            end
            if (handshake) begin
                valid <= 1'b0;
                s     <= '0;
            end
        end
    end
endmodule
